// File: rtl/mux_rr_pkg.sv
// Shared definitions for the round-robin registered mux.
//   sel_width(n) : channel-index width, clog2(n) but never below 1
//   ch_idx_t     : channel index wide enough for the largest supported N
//   PTR_RST      : round-robin pointer value after reset
package mux_rr_pkg;

   localparam int MAX_N = 16;

   function automatic int sel_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

   localparam int MAX_SEL_W = sel_width(MAX_N);

   typedef logic [MAX_SEL_W-1:0] ch_idx_t;

   localparam ch_idx_t PTR_RST = '0;

endpackage

// File: rtl/mux_rr_reg_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i     : per-channel request
//   ptr_i     : highest-priority channel; search runs upward from here and wraps
//   gnt_o     : one-hot grant, zero when nobody requests
//   gnt_idx_o : index of the granted channel (0 when none)
//   gnt_any_o : at least one request present
module rr_arbiter
   import mux_rr_pkg::*;
#(
   parameter int N     = 4,
   parameter int SEL_W = sel_width(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [SEL_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [SEL_W-1:0] gnt_idx_o,
   output logic             gnt_any_o
);

   // Walk offsets from farthest to nearest so the nearest requester
   // (lowest offset from ptr) is the last one written and therefore wins.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         int i;
         i = int'(ptr_i) + k;
         if (i >= N) begin
            i = i - N;
         end
         if (req_i[i]) begin
            gnt_o     = '0;
            gnt_o[i]  = 1'b1;
            gnt_idx_o = SEL_W'(i);
            gnt_any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_reg.sv
// N-channel round-robin mux with a one-deep registered output stage.
// Valid/ready handshake on every input channel and on the output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : per-channel valid            (N)
//   in_data    : channel i at [i*W +: W]       (N*W)
//   in_last    : per-channel end of packet     (N, only with MUX_RR_LOCK_EN)
//   in_ready   : per-channel accept, one-hot or zero (N)
//   out_valid  : output register holds a beat
//   out_data   : registered beat               (W)
//   out_sel    : source channel of out_data    (SEL_W)
//   out_ready  : consumer takes out_data this cycle
// Optional feature: define MUX_RR_LOCK_EN to hold the grant on one channel
// until it delivers a beat with in_last set (packet-atomic arbitration).
module mux_rr_reg
   import mux_rr_pkg::*;
#(
   parameter int N     = 4,
   parameter int W     = 8,
   parameter int SEL_W = sel_width(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     in_valid,
   input  logic [N*W-1:0]   in_data,
`ifdef MUX_RR_LOCK_EN
   input  logic [N-1:0]     in_last,
`endif
   output logic [N-1:0]     in_ready,
   output logic             out_valid,
   output logic [W-1:0]     out_data,
   output logic [SEL_W-1:0] out_sel,
   input  logic             out_ready
);

   logic [N-1:0]     req;
   logic [N-1:0]     gnt;
   logic [SEL_W-1:0] gnt_idx;
   logic             gnt_any;
   logic             load;
   logic             xfer;
   logic [SEL_W-1:0] ptr_nxt;
   logic [W-1:0]     sel_data;

   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_data_q, out_data_d;
   logic [SEL_W-1:0] out_sel_q, out_sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

`ifdef MUX_RR_LOCK_EN
   logic             lock_q, lock_d;
   logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
   logic [N-1:0]     lock_mask;

   always_comb begin
      lock_mask            = '0;
      lock_mask[lock_ch_q] = 1'b1;
   end

   // While locked only the owning channel may be granted; ptr has not moved,
   // so masking its request is enough to steer the arbiter.
   assign req = lock_q ? (in_valid & lock_mask) : in_valid;
`else
   assign req = in_valid;
`endif

   rr_arbiter #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_arb (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_any_o (gnt_any)
   );

   assign load     = ~out_valid_q | out_ready;
   // rst_n gates in_ready so producers see no accept while reset is held.
   assign in_ready = (rst_n & load) ? gnt : '0;
   assign xfer     = rst_n & load & gnt_any;
   assign ptr_nxt  = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
   assign sel_data = in_data[int'(gnt_idx) * W +: W];

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
`ifdef MUX_RR_LOCK_EN
      lock_d      = lock_q;
      lock_ch_d   = lock_ch_q;
`endif
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_sel_d   = gnt_idx;
`ifdef MUX_RR_LOCK_EN
         if (in_last[gnt_idx]) begin
            lock_d = 1'b0;
            ptr_d  = ptr_nxt;
         end else begin
            lock_d    = 1'b1;
            lock_ch_d = gnt_idx;
         end
`else
         ptr_d = ptr_nxt;
`endif
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= SEL_W'(PTR_RST);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end

`ifdef MUX_RR_LOCK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q    <= 1'b0;
         lock_ch_q <= '0;
      end else begin
         lock_q    <= lock_d;
         lock_ch_q <= lock_ch_d;
      end
   end
`endif

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
module tb_mux_rr_reg;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0] in_last;
   logic [N-1:0] in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   out_sel;
   logic         out_ready;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [W-1:0] d;
      logic [1:0]   s;
   } beat_t;
   beat_t sb[$];

   always #5 clk = ~clk;

   mux_rr_reg #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
`ifdef MUX_RR_LOCK_EN
      .in_last   (in_last),
`endif
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   // Reference model: arbitration, pointer, lock and output-valid state.
   // Inputs are sampled at the falling edge; state moves at the rising edge.
   int   m_ptr = 0;
   bit   m_outv = 0;
   bit   m_lock = 0;
   int   m_lock_ch = 0;

   initial begin
      bit         p_pop, p_xfer, p_last, found;
      int         g, idx;
      logic [N-1:0] req, exp_rdy;
      bit         m_load;
      beat_t      b;
      forever begin
         @(negedge clk);
         p_pop  = 0;
         p_xfer = 0;
         p_last = 1;
         if (!rst_n) begin
            m_ptr = 0; m_outv = 0; m_lock = 0;
            sb.delete();
            checks++;
            if (in_ready !== '0) begin
               failures++;
               $display("FAIL sb_rdy_in_reset: in_ready=%b expected 0000", in_ready);
            end
         end else begin
            m_load = !m_outv || out_ready;
            req = in_valid;
            if (m_lock) req = in_valid & (4'b0001 << m_lock_ch);
            found = 0;
            g = 0;
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr + k) % N;
               if (!found && req[idx]) begin
                  found = 1;
                  g = idx;
               end
            end
            exp_rdy = (m_load && found) ? (4'b0001 << g) : 4'b0000;
            checks++;
            if (in_ready !== exp_rdy) begin
               failures++;
               $display("FAIL sb_in_ready: got %b expected %b (ptr=%0d)", in_ready, exp_rdy, m_ptr);
            end
            checks++;
            if (out_valid !== m_outv) begin
               failures++;
               $display("FAIL sb_out_valid: got %b expected %b", out_valid, m_outv);
            end
            if (m_outv && out_ready) begin
               p_pop = 1;
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("FAIL sb_empty: output handshake with no expected beat");
               end else begin
                  b = sb.pop_front();
                  if (out_data !== b.d || out_sel !== b.s) begin
                     failures++;
                     $display("FAIL sb_beat: got data=%h sel=%0d expected data=%h sel=%0d",
                              out_data, out_sel, b.d, b.s);
                  end
               end
            end
            if (m_load && found) begin
               p_xfer = 1;
`ifdef MUX_RR_LOCK_EN
               p_last = in_last[g];
`endif
               b.d = in_data[g*W +: W];
               b.s = 2'(g);
               sb.push_back(b);
            end
         end
         @(posedge clk);
         if (!rst_n) begin
            m_ptr = 0; m_outv = 0; m_lock = 0;
            sb.delete();
         end else begin
            if (p_pop) m_outv = 0;
            if (p_xfer) begin
               m_outv = 1;
               if (p_last) begin
                  m_lock = 0;
                  m_ptr  = (g + 1) % N;
               end else begin
                  m_lock    = 1;
                  m_lock_ch = g;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int ch, input logic [W-1:0] v);
      in_data[ch*W +: W] = v;
   endtask

   task automatic test_reset();
      rst_n = 0; in_valid = 4'hF; in_data = '0; in_last = 4'hF; out_ready = 0;
      #2;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
         failures++;
         $display("FAIL reset_outputs: valid=%b data=%h sel=%0d expected 0/00/0", out_valid, out_data, out_sel);
      end
      checks++;
      if (in_ready !== 4'b0000) begin
         failures++;
         $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
      end
      in_valid = 4'b0001;
      set_data(0, 8'h5A);
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
         failures++;
         $display("FAIL reset_load: valid=%b data=%h expected 1/5a", out_valid, out_data);
      end
      in_valid = 4'hF;
      @(negedge clk);
      #1 rst_n = 0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 4'b0000) begin
         failures++;
         $display("FAIL reset_async: valid=%b data=%h in_ready=%b expected 0/00/0000",
                  out_valid, out_data, in_ready);
      end
      in_valid = 4'b0000;
      @(posedge clk);
      #3 rst_n = 1;
      checks++;
      if (dut.ptr_q !== 2'd0) begin
         failures++;
         $display("FAIL reset_ptr: got %0d expected 0", dut.ptr_q);
      end
      tick();
   endtask

   task automatic test_round_robin();
      for (int i = 0; i < N; i++) set_data(i, 8'(i));
      in_valid = 4'hF; out_ready = 1;
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_sel !== 2'(k % N) || out_data !== 8'(k % N)) begin
            failures++;
            $display("FAIL rr_seq[%0d]: valid=%b sel=%0d data=%h expected 1/%0d/%h",
                     k, out_valid, out_sel, out_data, k % N, k % N);
         end
      end
      in_valid = 4'b0000;
      tick();
      checks++;
      if (out_valid !== 1'b0 || dut.ptr_q !== 2'd0) begin
         failures++;
         $display("FAIL rr_drain: valid=%b ptr=%0d expected 0/0", out_valid, dut.ptr_q);
      end
   endtask

   task automatic test_single();
      in_valid = 4'b0100; set_data(2, 8'h3C); out_ready = 1;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         failures++;
         $display("FAIL single_rdy: got %b expected 0100", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 2'd2 || dut.ptr_q !== 2'd3) begin
         failures++;
         $display("FAIL single_out: valid=%b data=%h sel=%0d ptr=%0d expected 1/3c/2/3",
                  out_valid, out_data, out_sel, dut.ptr_q);
      end
      in_valid = 4'b0000;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_drain: valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_wrap();
      in_valid = 4'b0011; set_data(0, 8'hA0); set_data(1, 8'hA1); out_ready = 1;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         failures++;
         $display("FAIL wrap_rdy0: got %b expected 0001", in_ready);
      end
      tick();
      checks++;
      if (out_sel !== 2'd0 || out_data !== 8'hA0 || dut.ptr_q !== 2'd1 || in_ready !== 4'b0010) begin
         failures++;
         $display("FAIL wrap_first: sel=%0d data=%h ptr=%0d rdy=%b expected 0/a0/1/0010",
                  out_sel, out_data, dut.ptr_q, in_ready);
      end
      in_valid = 4'b0011;
      tick();
      checks++;
      if (out_sel !== 2'd1 || out_data !== 8'hA1 || dut.ptr_q !== 2'd2) begin
         failures++;
         $display("FAIL wrap_skip: sel=%0d data=%h ptr=%0d expected 1/a1/2", out_sel, out_data, dut.ptr_q);
      end
      in_valid = 4'b0000;
      tick();
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < N; i++) set_data(i, 8'hC0 + 8'(i));
      in_valid = 4'hF; out_ready = 0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'hC2 || dut.ptr_q !== 2'd3) begin
         failures++;
         $display("FAIL bp_load: valid=%b sel=%0d data=%h ptr=%0d expected 1/2/c2/3",
                  out_valid, out_sel, out_data, dut.ptr_q);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_rdy[%0d]: got %b expected 0000", k, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'hC2 || dut.ptr_q !== 2'd3) begin
            failures++;
            $display("FAIL bp_hold[%0d]: valid=%b sel=%0d data=%h ptr=%0d expected 1/2/c2/3",
                     k, out_valid, out_sel, out_data, dut.ptr_q);
         end
      end
      out_ready = 1;
      #1;
      checks++;
      if (in_ready !== 4'b1000) begin
         failures++;
         $display("FAIL bp_release_rdy: got %b expected 1000", in_ready);
      end
      tick();
      checks++;
      if (out_sel !== 2'd3 || out_data !== 8'hC3) begin
         failures++;
         $display("FAIL bp_release: sel=%0d data=%h expected 3/c3", out_sel, out_data);
      end
      in_valid = 4'b0000;
      tick();
   endtask

`ifdef MUX_RR_LOCK_EN
   task automatic test_lock();
      // ptr is 0 here; one ch0 beat moves it to 1.
      in_valid = 4'b0001; in_last = 4'hF; set_data(0, 8'hD0); out_ready = 1;
      tick();
      in_valid = 4'b0111; in_last = 4'b0101;
      set_data(0, 8'hE0); set_data(1, 8'hB1); set_data(2, 8'hE2);
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
         failures++;
         $display("FAIL lock_first_rdy: got %b expected 0010", in_ready);
      end
      tick();
      checks++;
      if (out_sel !== 2'd1 || out_data !== 8'hB1) begin
         failures++;
         $display("FAIL lock_beat1: sel=%0d data=%h expected 1/b1", out_sel, out_data);
      end
      in_valid = 4'b0101;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         failures++;
         $display("FAIL lock_gap_rdy: got %b expected 0000", in_ready);
      end
      tick();
      in_valid = 4'b0111; set_data(1, 8'hB2);
      tick();
      checks++;
      if (out_sel !== 2'd1 || out_data !== 8'hB2) begin
         failures++;
         $display("FAIL lock_beat2: sel=%0d data=%h expected 1/b2", out_sel, out_data);
      end
      set_data(1, 8'hB3); in_last = 4'b0111;
      tick();
      checks++;
      if (out_sel !== 2'd1 || out_data !== 8'hB3) begin
         failures++;
         $display("FAIL lock_beat3: sel=%0d data=%h expected 1/b3", out_sel, out_data);
      end
      in_valid = 4'b0101;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         failures++;
         $display("FAIL lock_release_rdy: got %b expected 0100", in_ready);
      end
      tick();
      checks++;
      if (out_sel !== 2'd2 || out_data !== 8'hE2) begin
         failures++;
         $display("FAIL lock_next: sel=%0d data=%h expected 2/e2", out_sel, out_data);
      end
      in_valid = 4'b0001;
      tick();
      checks++;
      if (out_sel !== 2'd0 || out_data !== 8'hE0) begin
         failures++;
         $display("FAIL lock_last: sel=%0d data=%h expected 0/e0", out_sel, out_data);
      end
      in_valid = 4'b0000;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_wrap();
      test_backpressure();
`ifdef MUX_RR_LOCK_EN
      test_lock();
`endif
      tick();
      checks++;
      if (sb.size() != 0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL final_drain: pending=%0d valid=%b expected 0/0", sb.size(), out_valid);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised successor to the team's 2:1 combinational mux.
- Selects one of N W-bit input channels by round-robin arbitration and presents the winner through a one-deep registered output stage with valid/ready handshake on every port.
- Sits between multiple producers and a single shared consumer, for example several sources feeding one bus.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel in bits.
- SEL_W, $clog2(N), width of the channel-index output (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  N  per-channel data-valid.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds valid data.
- out_data  output  W  registered data.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-transfer):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - in_ready all 0 while rst_n is low.
  - Any in-flight beat is discarded.
- load = ~out_valid | out_ready: the output register can take a new beat this cycle.
- Arbitration (combinational):
  - grant = the first channel i with in_valid[i]=1, searching from ptr upward with wrap N-1 -> 0.
  - No requester: grant is none.
- in_ready[i] = load & (grant==i). It must not depend on in_valid of other channels beyond arbitration.
- Input transfer: in_valid[g] & in_ready[g]. On the rising edge:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - ptr <= (g==N-1) ? 0 : g+1.
- Output transfer (out_valid & out_ready) with no input transfer: out_valid <= 0; out_data and out_sel hold.
- Simultaneous output and input transfer: new beat replaces old in the same edge. Full throughput is 1 beat/cycle.
- Output stall (out_valid=1, out_ready=0):
  - in_ready all 0; out_data, out_sel and ptr are stable.
  - Producers must hold in_valid/in_data (AXI-style: valid, once asserted, stays until accepted).
- Latency: input accepted at edge k appears on out_data after edge k (1 cycle).
- ptr advances only on an input transfer, never on idle cycles.
- Fairness: with all N channels continuously valid, each channel is granted exactly once per N transfers.
- N not a power of two: ptr wraps at N-1, never reaches unused codes.

Optional Feature:
- Macro: MUX_RR_LOCK_EN.
- Defined:
  - Adds port in_last, input, N bits, marking the final beat of a packet per channel.
  - After a transfer from channel g with in_last[g]=0, the grant is locked to g. Other channels get no in_ready even if g drops in_valid.
  - Lock releases on transfer of a beat with in_last[g]=1; ptr advances only then.
  - Reset clears the lock.
- Undefined: no in_last port; every beat is arbitrated independently as above.

Decomposition:
- Package mux_rr_pkg:
  - Function sel_width(n) returning clog2 with a minimum of 1.
  - Typedef of the channel index type.
  - Constant for the reset pointer value (0).
- Sub-module rr_arbiter(N):
  - Inputs: req[N], ptr.
  - Outputs: gnt one-hot, gnt_idx, gnt_any.
  - Purely combinational.
- Top level holds ptr, the optional lock, and the output register.

Test Plan (all with N=4, W=8):
- Reset mid-stream: out_valid=1, out_data=0x5A, then rst_n low asynchronously between edges -> out_valid=0, out_data=0, in_ready=0000 immediately; after release, ptr=0.
- Single requester: in_valid=0100, in_data[2]=0x3C, out_ready=1 -> in_ready=0100; after next edge out_data=0x3C, out_sel=2, out_valid=1, ptr=3.
- All valid, out_ready=1, 8 cycles, data = channel index -> out_sel sequence 0,1,2,3,0,1,2,3 with no bubbles.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles, all in_valid=1 -> in_ready=0000, out_data/out_sel unchanged, ptr unchanged; out_ready=1 -> next grant is the stalled ptr.
- Wrap and skip: ptr=3, in_valid=0011 -> grant 0 (wrap), then ptr=1 -> grant 1.
- MUX_RR_LOCK_EN: ch1 sends 3 beats with in_last=0,0,1 while ch0 and ch2 are valid -> out_sel=1,1,1, then 2; ch0 gets in_ready only after ch2.
